nread_target: RTL
=================

# nread_target

Target-side NREAD and doorbell responder for the SRIO controller. It accepts HELLO-format request packets from the SRIO core's target request stream (`s_axis_treq`) and serves NREADs by issuing AXI4 read bursts to local memory. Read data is byte-swapped to SRIO big-endian order and returned as a response-with-data packet on `m_axis_tresp`. It is the remote counterpart of the NREAD/doorbell initiator engine.

## Interface
Parameters:
- `MAX_BURST`, 16: AXI read burst length cap in beats. Must be a power of two, 16 or less.

Ports:
- `aclk`  in  1  clock
- `aresetn`  in  1  reset; asynchronous, active-low
- `addr_offset`  in  32  added to the request address to form the local AXI address; sampled at header accept
- `s_axis_treq_tvalid/tready/tlast`  in/out/in  1  target request stream handshake
- `s_axis_treq_tdata`  in  64  HELLO request beat
- `s_axis_treq_tkeep`  in  8  ignored
- `m_axis_tresp_tvalid/tready/tlast`  out/in/out  1  target response stream handshake
- `m_axis_tresp_tdata`  out  64  response header or data
- `m_axis_tresp_tkeep`  out  8  always 8'hFF
- `m_axi_araddr`  out  32  burst address
- `m_axi_arlen`  out  8  burst length minus 1
- `m_axi_arsize`  out  3  constant 3'b011
- `m_axi_arburst`  out  2  constant 2'b01 (INCR)
- `m_axi_arvalid/arready`  out/in  1  AR handshake
- `m_axi_rdata`  in  64  read data
- `m_axi_rresp`  in  2  read response
- `m_axi_rlast/rvalid`  in  1  R channel
- `m_axi_rready`  out  1  R channel ready
- `rd_err`  out  1  sticky; set on any `rresp != 0`; cleared only by reset
- `unsup_cnt`  out  8  count of dropped requests; wraps at 255
- `db_valid`  out  1  one-cycle pulse per doorbell received (`NREAD_TARGET_DB_EN` only)
- `db_info`  out  16  doorbell info, held until the next doorbell

## Operation
- Request header fields: TID [63:56], ftype/ttype [55:48], prio [46:45], CRF [44], size [43:36] (bytes−1), addr [31:0].
- States: IDLE, DRAIN, AR, HDR, DATA, DB_RESP.
- IDLE: `treq_tready=1`. The header is registered on handshake.
  - 8'h24 with `size[2:0]==3'b111` and tlast=1 → AR. Beats = `size[7:3]+1`, 1..32.
  - 8'hA0 with tlast=1 (DB_EN) → DB_RESP; `db_valid` pulses.
  - Any other header, or tlast=0 → `unsup_cnt`+1. With tlast=0 → DRAIN, else stay in IDLE.
- DRAIN: `tready=1` until a tlast beat, then IDLE. No response is sent.
- AR: `arvalid=1`, `arlen = min(MAX_BURST, remaining)−1`. On handshake: address += (arlen+1)·8, remaining −= arlen+1. Go to HDR for the first burst, otherwise DATA.
- HDR: tresp_tdata = {TID, 8'hD8, 1'b0, prio_r, CRF, 44'b0}.
  - prio_r = prio+1, saturating at 3.
  - tlast=0.
  - Handshake → DATA.
- DATA: pass-through.
  - `tresp_tvalid = rvalid`, `rready = tresp_tready`.
  - tdata = rdata with the byte order reversed (byte 0 ↔ byte 7).
  - tlast = rlast AND remaining==0.
  - On rlast handshake: if remaining>0 → AR, else → IDLE.
- DB_RESP: tdata = {TID, 8'hD0, 1'b0, prio_r, CRF, 44'b0}, tlast=1. Handshake → IDLE.
- Only one request is in flight at a time. `treq_tready=0` outside IDLE and DRAIN.

## Timing
- Reset values:
  - All valids and readies 0, except `treq_tready`, which is 1 once out of reset (IDLE).
  - araddr, arlen, tdata, `unsup_cnt`, `db_info` all 0; `rd_err=0`; state IDLE.
- Header accept → arvalid: 1 cycle (registered).
- AR handshake → HDR tvalid: 1 cycle.
- DATA path is combinational rdata→tdata with zero latency. No R beat may be dropped or duplicated under any combination of `rvalid` and `tready`.
- Back-to-back: IDLE is re-entered the cycle after the final handshake, so the next header can be accepted that cycle.
- `arvalid` and `tresp_tvalid` must not be deasserted before their handshake.
- An `rresp` error does not abort the transfer. The full length is still returned and `rd_err` is set.
- Reset mid-operation: immediate return to IDLE and all outputs reset. No partial-packet recovery.

## Configuration
- `NREAD_TARGET_DB_EN` defined: ftype 8'hA0 is handled as a doorbell (DB_RESP, `db_valid`, `db_info`).
- Without it: the DB_RESP state and the doorbell logic are removed; 8'hA0 is counted in `unsup_cnt` and dropped; `db_valid` is tied to 0 and `db_info` to 0.

## Structure
- `nread_target_pkg`:
  - state enum
  - FTYPE constants: NREAD 8'h24, DOORB 8'hA0, RESP_DATA 8'hD8, RESP_NODATA 8'hD0
  - header field bit positions
  - `bswap64` function
  - shared with the initiator engine
- No sub-module. The AR address/length generator stays inline.

## Test plan
- NREAD TID 8'h05, prio 1, size 8'h07, addr 0x100, offset 0x8000_0000:
  - AR 0x8000_0100, len 0.
  - Header 64'h05D8_4000_0000_0000.
  - One data beat, byte-swapped, tlast=1.
- NREAD size 8'hFF, addr 0x0:
  - ARs at 0x0 and 0x80, each len 15.
  - 33 tresp beats, tlast only on the 33rd.
- NREAD size 8'h8F (18 beats): AR len 15 at +0x0, then len 1 at +0x80; 19 tresp beats.
- Random `tready` and `rvalid` gaps over a 32-beat read: tresp data matches the swapped memory sequence exactly; `rready` mirrors `tready`.
- Doorbell TID 8'h80, info 0x1234 (DB_EN):
  - `db_valid` pulse with `db_info`=0x1234.
  - tresp 64'h80D0_4000_0000_0000, tlast=1.
- Error and reset handling:
  - 3-beat ftype 8'h54 packet: drained, `unsup_cnt`=1, no tresp.
  - `aresetn` low during DATA: returns to IDLE with all valids 0.

Source files
------------

// File: rtl/nread_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nread_target_pkg
// Description : Shared definitions for the SRIO NREAD/doorbell target and
//               initiator engines. Contains the FSM state encoding, HELLO
//               ftype/ttype codes, header field positions and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package nread_target_pkg;

    // FSM states of the target responder
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_AR      = 3'd2,
        ST_HDR     = 3'd3,
        ST_DATA    = 3'd4,
        ST_DB_RESP = 3'd5
    } state_t;

    // Combined ftype/ttype byte values of the HELLO header
    localparam logic [7:0] FTYPE_NREAD       = 8'h24;
    localparam logic [7:0] FTYPE_DOORB       = 8'hA0;
    localparam logic [7:0] FTYPE_RESP_DATA   = 8'hD8;
    localparam logic [7:0] FTYPE_RESP_NODATA = 8'hD0;

    // HELLO header field positions (LSB of each field)
    localparam int HDR_TID_LSB    = 56;
    localparam int HDR_FTYPE_LSB  = 48;
    localparam int HDR_PRIO_LSB   = 45;
    localparam int HDR_CRF_BIT    = 44;
    localparam int HDR_SIZE_LSB   = 36;
    localparam int HDR_ADDR_LSB   = 0;
    localparam int HDR_DBINFO_LSB = 16;

    // Reverse byte order of a 64-bit word (byte 0 <-> byte 7)
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

    // Response priority is one above the request, saturating at 3
    function automatic logic [1:0] prio_bump(input logic [1:0] p);
        return (p == 2'b11) ? p : p + 2'b01;
    endfunction

    // Response header: {TID, ftype, rsvd, prio, CRF, zeros}
    function automatic logic [63:0] resp_hdr(input logic [7:0] tid,
                                             input logic [7:0] ftype,
                                             input logic [1:0] prio,
                                             input logic       crf);
        return {tid, ftype, 1'b0, prio, crf, 44'd0};
    endfunction

    // Beats of the next AXI burst: remaining beats clipped to the cap
    function automatic logic [5:0] burst_beats(input logic [5:0] remaining,
                                               input logic [5:0] cap);
        return (remaining > cap) ? cap : remaining;
    endfunction

endpackage : nread_target_pkg
`default_nettype wire

// File: rtl/nread_target.sv
`default_nettype none
// ============================================================================
// Module      : nread_target
// Description : SRIO target-side NREAD and doorbell responder. Accepts HELLO
//               requests on s_axis_treq, reads local memory over AXI4 and
//               returns byte-swapped response-with-data packets on
//               m_axis_tresp. Doorbells are answered with a no-data response.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   NREAD_TARGET_DB_EN  - when defined, ftype 8'hA0 is handled as a doorbell;
//                         otherwise it is counted in unsup_cnt and dropped.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   addr_offset           added to request address, sampled at header accept
//   s_axis_treq_*         HELLO request stream (tkeep ignored)
//   m_axis_tresp_*        response stream (header then data)
//   m_axi_ar*/r*          AXI4 read channels to local memory
//   rd_err                sticky flag, any non-OKAY read response
//   unsup_cnt             count of dropped requests (wraps)
//   db_valid, db_info     doorbell pulse and held info
// ============================================================================
module nread_target
    import nread_target_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] addr_offset,

    input  logic        s_axis_treq_tvalid,
    output logic        s_axis_treq_tready,
    input  logic        s_axis_treq_tlast,
    input  logic [63:0] s_axis_treq_tdata,
    input  logic [7:0]  s_axis_treq_tkeep,

    output logic        m_axis_tresp_tvalid,
    input  logic        m_axis_tresp_tready,
    output logic        m_axis_tresp_tlast,
    output logic [63:0] m_axis_tresp_tdata,
    output logic [7:0]  m_axis_tresp_tkeep,

    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    output logic        rd_err,
    output logic [7:0]  unsup_cnt,
    output logic        db_valid,
    output logic [15:0] db_info
);

    localparam logic [5:0] C_MAX_BURST = 6'(MAX_BURST);

    state_t      state_q, state_d;
    logic [7:0]  tid_q, tid_d;
    logic [1:0]  prio_q, prio_d;          // already bumped for the response
    logic        crf_q, crf_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [5:0]  remaining_q, remaining_d; // beats not yet requested on AR
    logic        first_q, first_d;         // next AR is the first burst
    logic        rd_err_q, rd_err_d;
    logic [7:0]  unsup_cnt_q, unsup_cnt_d;

    // Header field decode
    logic [7:0]  w_hdr_tid;
    logic [7:0]  w_hdr_ftype;
    logic [1:0]  w_hdr_prio;
    logic        w_hdr_crf;
    logic [7:0]  w_hdr_size;
    logic [31:0] w_hdr_addr;
    logic [5:0]  w_hdr_beats;
    logic        w_is_nread;
    logic [5:0]  w_ar_beats;
    logic [5:0]  w_rem_after;
    logic        unused_inputs;

    assign w_hdr_tid   = s_axis_treq_tdata[HDR_TID_LSB   +: 8];
    assign w_hdr_ftype = s_axis_treq_tdata[HDR_FTYPE_LSB +: 8];
    assign w_hdr_prio  = s_axis_treq_tdata[HDR_PRIO_LSB  +: 2];
    assign w_hdr_crf   = s_axis_treq_tdata[HDR_CRF_BIT];
    assign w_hdr_size  = s_axis_treq_tdata[HDR_SIZE_LSB  +: 8];
    assign w_hdr_addr  = s_axis_treq_tdata[HDR_ADDR_LSB  +: 32];
    assign w_hdr_beats = {1'b0, w_hdr_size[7:3]} + 6'd1;

    // Only whole 8-byte multiples in a single-beat request are served
    assign w_is_nread  = s_axis_treq_tlast && (w_hdr_ftype == FTYPE_NREAD) &&
                         (w_hdr_size[2:0] == 3'b111);

    assign w_ar_beats  = arlen_q[5:0] + 6'd1;
    assign w_rem_after = remaining_q - w_ar_beats;

    assign unused_inputs = ^{s_axis_treq_tkeep, s_axis_treq_tdata[47],
                             s_axis_treq_tdata[35:32]};

    assign m_axi_araddr       = araddr_q;
    assign m_axi_arlen        = arlen_q;
    assign m_axi_arsize       = 3'b011;
    assign m_axi_arburst      = 2'b01;
    assign m_axis_tresp_tkeep = 8'hFF;
    assign rd_err             = rd_err_q;
    assign unsup_cnt          = unsup_cnt_q;

`ifdef NREAD_TARGET_DB_EN
    logic        db_valid_q, db_valid_d;
    logic [15:0] db_info_q, db_info_d;
    logic        w_is_doorb;

    assign w_is_doorb = s_axis_treq_tlast && (w_hdr_ftype == FTYPE_DOORB);
    assign db_valid   = db_valid_q;
    assign db_info    = db_info_q;
`else
    assign db_valid   = 1'b0;
    assign db_info    = 16'd0;
`endif

    always_comb begin
        state_d     = state_q;
        tid_d       = tid_q;
        prio_d      = prio_q;
        crf_d       = crf_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        rd_err_d    = rd_err_q;
        unsup_cnt_d = unsup_cnt_q;
`ifdef NREAD_TARGET_DB_EN
        db_valid_d  = 1'b0;
        db_info_d   = db_info_q;
`endif
        s_axis_treq_tready  = 1'b0;
        m_axi_arvalid       = 1'b0;
        m_axi_rready        = 1'b0;
        m_axis_tresp_tvalid = 1'b0;
        m_axis_tresp_tlast  = 1'b0;
        m_axis_tresp_tdata  = 64'd0;

        case (state_q)
            ST_IDLE: begin
                s_axis_treq_tready = 1'b1;
                if (s_axis_treq_tvalid) begin
                    tid_d  = w_hdr_tid;
                    prio_d = prio_bump(w_hdr_prio);
                    crf_d  = w_hdr_crf;
                    if (w_is_nread) begin
                        araddr_d    = addr_offset + w_hdr_addr;
                        remaining_d = w_hdr_beats;
                        arlen_d     = {2'b00, burst_beats(w_hdr_beats, C_MAX_BURST) - 6'd1};
                        first_d     = 1'b1;
                        state_d     = ST_AR;
                    end
`ifdef NREAD_TARGET_DB_EN
                    else if (w_is_doorb) begin
                        db_valid_d = 1'b1;
                        db_info_d  = s_axis_treq_tdata[HDR_DBINFO_LSB +: 16];
                        state_d    = ST_DB_RESP;
                    end
`endif
                    else begin
                        unsup_cnt_d = unsup_cnt_q + 8'd1;
                        if (!s_axis_treq_tlast) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                s_axis_treq_tready = 1'b1;
                if (s_axis_treq_tvalid && s_axis_treq_tlast) begin
                    state_d = ST_IDLE;
                end
            end

            ST_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    araddr_d    = araddr_q + {23'd0, w_ar_beats, 3'd0};
                    remaining_d = w_rem_after;
                    // Length of the following burst; untouched when none is left
                    if (w_rem_after != 6'd0) begin
                        arlen_d = {2'b00, burst_beats(w_rem_after, C_MAX_BURST) - 6'd1};
                    end
                    first_d = 1'b0;
                    state_d = first_q ? ST_HDR : ST_DATA;
                end
            end

            ST_HDR: begin
                m_axis_tresp_tvalid = 1'b1;
                m_axis_tresp_tdata  = resp_hdr(tid_q, FTYPE_RESP_DATA, prio_q, crf_q);
                if (m_axis_tresp_tready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                // Zero-latency pass-through; R is only consumed when tresp is
                m_axis_tresp_tvalid = m_axi_rvalid;
                m_axi_rready        = m_axis_tresp_tready;
                m_axis_tresp_tdata  = bswap64(m_axi_rdata);
                m_axis_tresp_tlast  = m_axi_rlast && (remaining_q == 6'd0);
                if (m_axi_rvalid && m_axis_tresp_tready) begin
                    if (m_axi_rresp != 2'b00) begin
                        rd_err_d = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        state_d = (remaining_q != 6'd0) ? ST_AR : ST_IDLE;
                    end
                end
            end

`ifdef NREAD_TARGET_DB_EN
            ST_DB_RESP: begin
                m_axis_tresp_tvalid = 1'b1;
                m_axis_tresp_tlast  = 1'b1;
                m_axis_tresp_tdata  = resp_hdr(tid_q, FTYPE_RESP_NODATA, prio_q, crf_q);
                if (m_axis_tresp_tready) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            tid_q       <= 8'd0;
            prio_q      <= 2'd0;
            crf_q       <= 1'b0;
            araddr_q    <= 32'd0;
            arlen_q     <= 8'd0;
            remaining_q <= 6'd0;
            first_q     <= 1'b0;
            rd_err_q    <= 1'b0;
            unsup_cnt_q <= 8'd0;
`ifdef NREAD_TARGET_DB_EN
            db_valid_q  <= 1'b0;
            db_info_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            tid_q       <= tid_d;
            prio_q      <= prio_d;
            crf_q       <= crf_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            rd_err_q    <= rd_err_d;
            unsup_cnt_q <= unsup_cnt_d;
`ifdef NREAD_TARGET_DB_EN
            db_valid_q  <= db_valid_d;
            db_info_q   <= db_info_d;
`endif
        end
    end

endmodule : nread_target
`default_nettype wire
